// File: rtl/ram_bus_master_pkg.sv
// Shared definitions for the nibble RAM bus initiator: state encoding,
// nibble width, default geometry and the released-bus value.
package ram_bus_master_pkg;

  localparam int NIB_W       = 4;
  localparam int DEF_ADDR_W  = 12;
  localparam int DEF_MAX_NIB = 4;

  localparam logic [NIB_W-1:0] BUS_Z = 4'bzzzz;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_HOLD,
    ST_DONE
  } state_e;

endpackage

// File: rtl/ram_bus_master_buf.sv
// 4-bit tri-state driver for the shared RAM data bus; releases to Z when
// not enabled.
module ram_bus_master_buf
  import ram_bus_master_pkg::*;
(
  input  logic             en_i,
  input  logic [NIB_W-1:0] data_i,
  inout  wire  [NIB_W-1:0] bus_io
);

  assign bus_io = en_i ? data_i : BUS_Z;

endmodule

// File: rtl/ram_bus_master.sv
// Nibble RAM bus initiator: sequences SETUP/ACCESS/HOLD per nibble for 1..MAX_NIB
// nibble bursts, owns the data bus direction and collects read nibbles.
module ram_bus_master
  import ram_bus_master_pkg::*;
#(
  parameter  int ADDR_W  = DEF_ADDR_W,
  parameter  int MAX_NIB = DEF_MAX_NIB,
  localparam int LEN_W   = $clog2(MAX_NIB),
  localparam int DATA_W  = NIB_W * MAX_NIB
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              rw,
  input  logic [LEN_W-1:0]  len,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_cs,
  output logic              ram_we,
  inout  wire  [NIB_W-1:0]  ram_data
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  k_q, k_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              rw_q, rw_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              cs_q, cs_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [NIB_W-1:0]  wr_nib;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      k_q     <= '0;
      len_q   <= '0;
      rw_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cs_q    <= 1'b0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      k_q     <= k_d;
      len_q   <= len_d;
      rw_q    <= rw_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cs_q    <= cs_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Outputs are registered: each branch computes the values the next state shows.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    k_d     = k_q;
    len_d   = len_q;
    rw_d    = rw_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    cs_d    = 1'b0;
    we_d    = we_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req) begin
          rw_d    = rw;
          len_d   = len;
          wdata_d = wdata;
          addr_d  = addr;
          rdata_d = '0;
          k_d     = '0;
          we_d    = rw;
          busy_d  = 1'b1;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        busy_d  = 1'b1;
        cs_d    = 1'b1;
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        busy_d  = 1'b1;
        if (!rw_q) begin
          rdata_d[k_q*NIB_W +: NIB_W] = ram_data;
        end
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (k_q == len_q) begin
          done_d  = 1'b1;
          we_d    = 1'b0;
          state_d = ST_DONE;
        end else begin
          k_d     = k_q + 1'b1;
          addr_d  = addr_q + 1'b1;
          busy_d  = 1'b1;
          state_d = ST_SETUP;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign wr_nib = wdata_q[k_q*NIB_W +: NIB_W];

  // busy_q is low in IDLE/DONE, so the bus is released there even with rw_q still set.
  ram_bus_master_buf u_buf (
    .en_i   (rw_q & busy_q),
    .data_i (wr_nib),
    .bus_io (ram_data)
  );

  assign rdata    = rdata_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign ram_addr = addr_q;
  assign ram_cs   = cs_q;
  assign ram_we   = we_q;

endmodule

// File: tb/tb_ram_bus_master.sv
// Self-checking bench for ram_bus_master with a behavioural nibble RAM on the bus.
module tb_ram_bus_master;

  logic        clk;
  logic        reset;
  logic        req;
  logic        rw;
  logic [1:0]  len;
  logic [11:0] addr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        busy;
  logic        done;
  logic [11:0] ram_addr;
  logic        ram_cs;
  logic        ram_we;
  wire  [3:0]  ram_data;

  logic [3:0]  mem [0:4095];

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic        rw;
    logic [1:0]  len;
    logic [11:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  typedef struct {
    logic [15:0] rdata;
    int          nib;
  } exp_t;

  vec_t vecs[10];
  exp_t exp_q[$];

  ram_bus_master dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .rw       (rw),
    .len      (len),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .busy     (busy),
    .done     (done),
    .ram_addr (ram_addr),
    .ram_cs   (ram_cs),
    .ram_we   (ram_we),
    .ram_data (ram_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM: level-sensitive, drives only for cs=1/we=0.
  assign ram_data = (ram_cs && !ram_we) ? mem[ram_addr] : 4'bzzzz;
  always @(posedge clk) begin
    if (ram_cs && ram_we) mem[ram_addr] <= ram_data;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Scoreboard side: pop on every done pulse, count cs pulses per transfer,
  // and watch the bus rules on every cycle with cs activity.
  int   cs_cnt  = 0;
  logic prev_cs = 1'b0;
  logic prev_we = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      cs_cnt = 0;
    end else begin
      if (ram_cs) cs_cnt++;
      if (ram_cs) check("we_stable_into_cs", 32'(ram_we), 32'(prev_we));
      if (prev_cs) check("we_stable_out_of_cs", 32'(ram_we), 32'(prev_we));
      if (ram_cs && !ram_we && (dut.rw_q & dut.busy_q)) check("bus_contention", 32'd1, 32'd0);
      if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("rdata", 32'(rdata), 32'(e.rdata));
          check("cs_pulses", 32'(cs_cnt), 32'(e.nib));
          check("busy_at_done", 32'(busy), 32'd0);
        end
        cs_cnt = 0;
      end
    end
    prev_cs = ram_cs;
    prev_we = ram_we;
  end

  task automatic run_txn(input vec_t v);
    int cycles;
    @(negedge clk);
    rw    = v.rw;
    len   = v.len;
    addr  = v.addr;
    wdata = v.wdata;
    req   = 1'b1;
    exp_q.push_back('{rdata: v.exp_rdata, nib: int'(v.len) + 1});
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
      if (cycles == 1) req = 1'b0;
    end while (!done && cycles < 60);
    check("latency", 32'(cycles), 32'(v.exp_lat));
    $display("txn rw=%0d len=%0d addr=0x%03h wdata=0x%04h -> rdata=0x%04h after %0d cycles",
             v.rw, v.len, v.addr, v.wdata, rdata, cycles);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got simulation stuck expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{1'b1, 2'd0, 12'h123, 16'h0005, 16'h0000, 4};
    vecs[1] = '{1'b1, 2'd3, 12'h010, 16'hDCBA, 16'h0000, 13};
    vecs[2] = '{1'b0, 2'd3, 12'h010, 16'h0000, 16'hDCBA, 13};
    vecs[3] = '{1'b1, 2'd2, 12'hFFE, 16'h0321, 16'h0000, 10};
    vecs[4] = '{1'b0, 2'd2, 12'hFFE, 16'h0000, 16'h0321, 10};
    vecs[5] = '{1'b0, 2'd0, 12'h123, 16'h0000, 16'h0005, 4};
    vecs[6] = '{1'b1, 2'd3, 12'h200, 16'h9876, 16'h0000, 13};
    vecs[7] = '{1'b0, 2'd1, 12'h200, 16'h0000, 16'h0076, 7};
    vecs[8] = '{1'b0, 2'd2, 12'h201, 16'h0000, 16'h0987, 10};
    vecs[9] = '{1'b0, 2'd0, 12'h000, 16'h0000, 16'h0003, 4};

    reset = 1'b1; req = 1'b0; rw = 1'b0; len = 2'd0; addr = '0; wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy",  32'(busy),     32'd0);
    check("reset_done",  32'(done),     32'd0);
    check("reset_cs",    32'(ram_cs),   32'd0);
    check("reset_we",    32'(ram_we),   32'd0);
    check("reset_addr",  32'(ram_addr), 32'd0);
    check("reset_rdata", 32'(rdata),    32'd0);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) run_txn(vecs[i]);

    check("mem_123", 32'(mem[12'h123]), 32'h5);
    check("mem_ffe", 32'(mem[12'hFFE]), 32'h1);
    check("mem_fff", 32'(mem[12'hFFF]), 32'h2);
    check("mem_000", 32'(mem[12'h000]), 32'h3);

    // req held high: back-to-back transfers separated by DONE and one IDLE cycle.
    @(negedge clk);
    rw = 1'b0; len = 2'd0; addr = 12'h123; req = 1'b1;
    exp_q.push_back('{rdata: 16'h0005, nib: 1});
    exp_q.push_back('{rdata: 16'h0005, nib: 1});
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      check("held_req_done", 32'(done), 32'((c == 4) || (c == 9)));
      check("held_req_busy", 32'(busy), 32'(((c >= 1) && (c <= 3)) || ((c >= 6) && (c <= 8))));
      if (c == 9) req = 1'b0;
    end
    $display("txn held-req pair complete, rdata=0x%04h", rdata);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("held_req_quiet", 32'(done), 32'd0);
    end

    // Reset during ACCESS of nibble index 2 of a 4-nibble read.
    @(negedge clk);
    rw = 1'b0; len = 2'd3; addr = 12'h010; req = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) req = 1'b0;
    end
    check("abort_cs_in_access", 32'(ram_cs), 32'd1);
    check("abort_partial_rdata", 32'(rdata), 32'h00BA);
    reset = 1'b1;
    @(negedge clk);
    check("abort_busy",  32'(busy),     32'd0);
    check("abort_cs",    32'(ram_cs),   32'd0);
    check("abort_done",  32'(done),     32'd0);
    check("abort_rdata", 32'(rdata),    32'd0);
    check("abort_addr",  32'(ram_addr), 32'd0);
    reset = 1'b0;
    $display("txn aborted by reset, busy=%0d rdata=0x%04h", busy, rdata);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("abort_no_done", 32'(done), 32'd0);
    end
    run_txn(vecs[2]);

    repeat (2) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
